// File: rtl/rv_write_back.sv
// rv_write_back: RV32 write-back stage; load align/extend, regfile write, retire strobe and instret.
// Optional feature macro: RV_WRITE_BACK_FWD_EN adds forwarding outputs and a load-busy flag.
module rv_write_back #(
  parameter int IADDR_SPACE_BITS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic                        i_flush,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic [4:0]                  i_rd,
  input  logic                        i_reg_write,
  input  logic                        i_mem_read,
  input  logic [2:0]                  i_funct3,
  input  logic [1:0]                  i_addr_lo,
  input  logic [31:0]                 i_alu_res,
  input  logic [31:0]                 i_bus_data,
  input  logic                        i_bus_ack,
  output logic                        o_reg_write,
  output logic [4:0]                  o_rd,
  output logic [31:0]                 o_reg_data,
  output logic                        o_retire,
  output logic [IADDR_SPACE_BITS-1:0] o_retire_pc,
`ifdef RV_WRITE_BACK_FWD_EN
  output logic                        o_fwd_valid,
  output logic [4:0]                  o_fwd_rd,
  output logic [31:0]                 o_fwd_data,
  output logic                        o_load_busy,
`endif
  output logic [31:0]                 o_instret
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_LOAD = 1'b1;
  logic                        state_q, state_d;
  logic [4:0]                  p_rd_q, p_rd_d;
  logic                        p_rw_q, p_rw_d;
  logic [2:0]                  p_f3_q, p_f3_d;
  logic [1:0]                  p_addr_q, p_addr_d;
  logic [IADDR_SPACE_BITS-1:0] p_pc_q, p_pc_d;
  logic                        reg_write_q, reg_write_d;
  logic [4:0]                  rd_q, rd_d;
  logic [31:0]                 data_q, data_d;
  logic                        retire_q, retire_d;
  logic [IADDR_SPACE_BITS-1:0] retire_pc_q, retire_pc_d;
  logic [31:0]                 instret_q, instret_d;
  logic                        xfer;
  logic [7:0]                  ld_b;
  logic [15:0]                 ld_h;
  logic [31:0]                 ld_data;
  assign o_ready = (state_q == S_IDLE);
  assign xfer    = i_valid & o_ready & ~i_flush;
  // Select the addressed byte/half of the bus word and extend it per funct3.
  always_comb begin
    ld_b    = i_bus_data[{p_addr_q, 3'b000} +: 8];
    ld_h    = p_addr_q[1] ? i_bus_data[31:16] : i_bus_data[15:0];
    ld_data = (p_f3_q == 3'd0) ? {{24{ld_b[7]}}, ld_b} :
              (p_f3_q == 3'd4) ? {24'd0, ld_b} :
              (p_f3_q == 3'd1) ? {{16{ld_h[15]}}, ld_h} :
              (p_f3_q == 3'd5) ? {16'd0, ld_h} : i_bus_data;
  end
  // Next-state: capture in IDLE, retire non-loads at once, retire loads on ack.
  always_comb begin
    state_d     = state_q;
    p_rd_d      = p_rd_q;
    p_rw_d      = p_rw_q;
    p_f3_d      = p_f3_q;
    p_addr_d    = p_addr_q;
    p_pc_d      = p_pc_q;
    reg_write_d = 1'b0;
    retire_d    = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    retire_pc_d = retire_pc_q;
    instret_d   = instret_q;
    if (state_q == S_IDLE) begin
      if (xfer && i_mem_read) begin
        state_d  = S_LOAD;
        p_rd_d   = i_rd;
        p_rw_d   = i_reg_write;
        p_f3_d   = i_funct3;
        p_addr_d = i_addr_lo;
        p_pc_d   = i_pc;
      end else if (xfer) begin
        reg_write_d = i_reg_write & (i_rd != 5'd0);
        rd_d        = i_rd;
        data_d      = i_alu_res;
        retire_d    = 1'b1;
        retire_pc_d = i_pc;
        instret_d   = instret_q + 32'd1;
      end
    end else if (i_bus_ack) begin
      state_d     = S_IDLE;
      reg_write_d = p_rw_q & (p_rd_q != 5'd0);
      rd_d        = p_rd_q;
      data_d      = ld_data;
      retire_d    = 1'b1;
      retire_pc_d = p_pc_q;
      instret_d   = instret_q + 32'd1;
    end
  end
  // State and output registers; async reset drops any pending load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      p_rd_q      <= '0;
      p_rw_q      <= 1'b0;
      p_f3_q      <= '0;
      p_addr_q    <= '0;
      p_pc_q      <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      retire_q    <= 1'b0;
      retire_pc_q <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      p_rd_q      <= p_rd_d;
      p_rw_q      <= p_rw_d;
      p_f3_q      <= p_f3_d;
      p_addr_q    <= p_addr_d;
      p_pc_q      <= p_pc_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      retire_q    <= retire_d;
      retire_pc_q <= retire_pc_d;
      instret_q   <= instret_d;
    end
  end
  assign o_reg_write = reg_write_q;
  assign o_rd        = rd_q;
  assign o_reg_data  = data_q;
  assign o_retire    = retire_q;
  assign o_retire_pc = retire_pc_q;
  assign o_instret   = instret_q;
`ifdef RV_WRITE_BACK_FWD_EN
  assign o_fwd_valid = reg_write_q;
  assign o_fwd_rd    = rd_q;
  assign o_fwd_data  = data_q;
  assign o_load_busy = (state_q == S_LOAD);
`endif
endmodule

// File: tb/tb_rv_write_back.sv
// tb_rv_write_back: directed vector table plus multi-cycle corner sequences for rv_write_back.
module tb_rv_write_back;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, flush = 1'b0, reg_write = 1'b0, mem_read = 1'b0, bus_ack = 1'b0;
  logic [31:0] pc = '0, alu_res = '0, bus_data = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic [1:0]  addr_lo = '0;
  logic        ready, o_we, o_ret;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_pc, o_instret;
`ifdef RV_WRITE_BACK_FWD_EN
  logic        fwd_valid, load_busy;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif
  int n_cmp = 0, n_fail = 0;
  logic [31:0] exp_instret = 0;
  rv_write_back #(.IADDR_SPACE_BITS(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready), .i_flush(flush),
    .i_pc(pc), .i_rd(rd), .i_reg_write(reg_write), .i_mem_read(mem_read), .i_funct3(funct3),
    .i_addr_lo(addr_lo), .i_alu_res(alu_res), .i_bus_data(bus_data), .i_bus_ack(bus_ack),
    .o_reg_write(o_we), .o_rd(o_rd), .o_reg_data(o_data), .o_retire(o_ret), .o_retire_pc(o_pc),
`ifdef RV_WRITE_BACK_FWD_EN
    .o_fwd_valid(fwd_valid), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data), .o_load_busy(load_busy),
`endif
    .o_instret(o_instret)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        mem;
    logic [2:0]  f3;
    logic [1:0]  addr;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] bus;
    int          delay;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Offer one instruction, service the load if any, then check the retire outputs.
  task automatic run(input vec_t v, input int idx);
    logic [31:0] vpc;
    vpc = 32'h1000 + 32'(idx) * 4;
    @(negedge clk);
    valid = 1'b1; mem_read = v.mem; funct3 = v.f3; addr_lo = v.addr; rd = v.rd;
    reg_write = v.rw; alu_res = v.alu; pc = vpc; bus_data = v.bus;
    @(posedge clk); #1;
    valid = 1'b0;
    if (v.mem) begin
      for (int k = 0; k < v.delay; k++) begin
        chk($sformatf("v%0d wait_ready", idx), {31'd0, ready}, 32'd0);
        chk($sformatf("v%0d wait_retire", idx), {31'd0, o_ret}, 32'd0);
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d ack_ready", idx), {31'd0, ready}, 32'd0);
      @(negedge clk);
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    exp_instret++;
    chk($sformatf("v%0d retire", idx), {31'd0, o_ret}, 32'd1);
    chk($sformatf("v%0d we", idx), {31'd0, o_we}, {31'd0, v.exp_we});
    chk($sformatf("v%0d pc", idx), o_pc, vpc);
    chk($sformatf("v%0d instret", idx), o_instret, exp_instret);
    if (v.exp_we) begin
      chk($sformatf("v%0d rd", idx), {27'd0, o_rd}, {27'd0, v.rd});
      chk($sformatf("v%0d data", idx), o_data, v.exp_data);
    end
  endtask
  initial begin
    vecs[0]  = '{1'b0, 3'd0, 2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 0, 1'b1, 32'h0000_1234};
    vecs[1]  = '{1'b1, 3'd0, 2'd3, 5'd6, 1'b1, 32'h0, 32'h80FF_0000, 2, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 3'd4, 2'd3, 5'd7, 1'b1, 32'h0, 32'h80FF_0000, 2, 1'b1, 32'h0000_0080};
    vecs[3]  = '{1'b1, 3'd1, 2'd2, 5'd8, 1'b1, 32'h0, 32'h80FF_0000, 2, 1'b1, 32'hFFFF_80FF};
    vecs[4]  = '{1'b1, 3'd5, 2'd3, 5'd9, 1'b1, 32'h0, 32'h80FF_0000, 1, 1'b1, 32'h0000_80FF};
    vecs[5]  = '{1'b1, 3'd2, 2'd0, 5'd10, 1'b1, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 3'd3, 2'd1, 5'd11, 1'b1, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 3'd0, 2'd1, 5'd12, 1'b1, 32'h0, 32'h0000_8000, 0, 1'b1, 32'hFFFF_FF80};
    vecs[8]  = '{1'b1, 3'd1, 2'd1, 5'd13, 1'b1, 32'h0, 32'h0000_8001, 3, 1'b1, 32'hFFFF_8001};
    vecs[9]  = '{1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h0000_0005, 32'h0, 0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 3'd0, 2'd0, 5'd7, 1'b0, 32'h0000_0077, 32'h0, 0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 3'd4, 2'd2, 5'd0, 1'b1, 32'h0, 32'h0012_3456, 1, 1'b0, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst we", {31'd0, o_we}, 32'd0);
    chk("rst retire", {31'd0, o_ret}, 32'd0);
    chk("rst instret", o_instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run(vecs[i], i);
    @(posedge clk); #1;
    chk("pulse retire", {31'd0, o_ret}, 32'd0);
    chk("pulse we", {31'd0, o_we}, 32'd0);
    // back-to-back non-loads
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b0; reg_write = 1'b1; rd = 5'd1; alu_res = 32'd11; pc = 32'h2000;
    @(posedge clk); #1;
    exp_instret++;
    chk("b2b0 retire", {31'd0, o_ret}, 32'd1);
    chk("b2b0 data", o_data, 32'd11);
    chk("b2b0 ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rd = 5'd2; alu_res = 32'd22; pc = 32'h2004;
    @(posedge clk); #1;
    exp_instret++;
    chk("b2b1 retire", {31'd0, o_ret}, 32'd1);
    chk("b2b1 data", o_data, 32'd22);
    chk("b2b1 pc", o_pc, 32'h2004);
    chk("b2b1 instret", o_instret, exp_instret);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk); #1;
    chk("hold retire", {31'd0, o_ret}, 32'd0);
    chk("hold rd", {27'd0, o_rd}, 32'd2);
    chk("hold data", o_data, 32'd22);
    chk("hold pc", o_pc, 32'h2004);
    // ack in IDLE ignored; flush of an offered instruction
    @(negedge clk);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("idle ack retire", {31'd0, o_ret}, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0; valid = 1'b1; flush = 1'b1; rd = 5'd3; alu_res = 32'd33;
    @(posedge clk); #1;
    chk("flush retire", {31'd0, o_ret}, 32'd0);
    chk("flush instret", o_instret, exp_instret);
    chk("flush data", o_data, 32'd22);
    // flush during LOAD_WAIT does not cancel the captured load
    @(negedge clk);
    flush = 1'b0; mem_read = 1'b1; funct3 = 3'd2; rd = 5'd4; bus_data = 32'h1357_9BDF; pc = 32'h3000;
    @(posedge clk); #1;
    valid = 1'b1; flush = 1'b1; mem_read = 1'b0;
`ifdef RV_WRITE_BACK_FWD_EN
    chk("load_busy", {31'd0, load_busy}, 32'd1);
`endif
    @(negedge clk);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0; valid = 1'b0; flush = 1'b0;
    exp_instret++;
    chk("lflush retire", {31'd0, o_ret}, 32'd1);
    chk("lflush data", o_data, 32'h1357_9BDF);
    chk("lflush pc", o_pc, 32'h3000);
`ifdef RV_WRITE_BACK_FWD_EN
    chk("fwd valid", {31'd0, fwd_valid}, {31'd0, o_we});
    chk("fwd rd", {27'd0, fwd_rd}, 32'd4);
    chk("fwd data", fwd_data, 32'h1357_9BDF);
    chk("load_busy idle", {31'd0, load_busy}, 32'd0);
`endif
    // reset while a load is pending
    @(negedge clk);
    valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; rd = 5'd9; bus_data = 32'hAAAA_5555;
    @(posedge clk); #1;
    valid = 1'b0; mem_read = 1'b0;
    chk("pre-rst ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-rst ready", {31'd0, ready}, 32'd1);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("mid-rst retire", {31'd0, o_ret}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus_ack = 1'b0;
    exp_instret = 0;
    @(negedge clk);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("post-rst retire", {31'd0, o_ret}, 32'd0);
    chk("post-rst ready", {31'd0, ready}, 32'd1);
    chk("post-rst instret", o_instret, 32'd0);
    // instret wrap
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    valid = 1'b1; reg_write = 1'b1; rd = 5'd0; alu_res = 32'd1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("wrap retire", {31'd0, o_ret}, 32'd1);
    chk("wrap instret", o_instret, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
